dbi_burst_ctrl: RTL and testbench
=================================

// Module: dbi_burst_ctrl
// PURPOSE
//  Byte-lane DBI transmit controller. Accepts a write burst beat by beat, decides per beat
//  whether to invert the byte (DBI-DC: minimise zeros; DBI-AC: minimise toggles against the
//  previously driven byte) and drives encoded DQ plus the DBI flag toward the PHY.
//  Enforces the burst length and an inter-burst gap. Reports per-burst inversion statistics.
// PARAMETERS
//  BL      8  beats per burst (2..255)
//  GAP_CYC 2  idle cycles forced after each burst's last beat is accepted downstream (0..15)
//  W       8  lane width; fixed at 8, because the decision voter is 9-input
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  cfg_en       in   1  1 = DBI enabled, 0 = pass-through with dbi_inv = 0
//  cfg_mode     in   1  0 = DBI-DC, 1 = DBI-AC
//  s_valid      in   1  input beat valid
//  s_ready      out  1  input beat accepted when s_valid & s_ready
//  s_data       in   8  raw byte
//  o_valid      out  1  encoded beat valid
//  o_ready      in   1  downstream accepts when o_valid & o_ready
//  o_dq         out  8  encoded byte
//  o_dbi        out  1  1 = o_dq is the inverted s_data
//  o_last       out  1  marks beat BL-1 of the burst
//  done         out  1  1-cycle pulse when the last beat is accepted downstream
//  inv_cnt      out  8  number of inverted beats in the burst just completed; valid with done
// BEHAVIOUR
//  Reset values: s_ready=0, o_valid=0, o_dq=8'hFF, o_dbi=0, o_last=0, done=0, inv_cnt=0.
//    FSM = IDLE, beat counter = 0, AC reference prev = 8'hFF (bus parked high).
//  FSM states:
//    IDLE  s_ready=1. First accepted beat latches cfg_en/cfg_mode for the whole burst
//          and moves to BURST.
//    BURST s_ready = !o_valid | o_ready (single output register, no skid buffer).
//          Each accepted beat increments the beat counter.
//          When the beat with count = BL-1 is accepted, s_ready=0 until done.
//          done -> GAP (GAP_CYC>0), otherwise -> IDLE.
//    GAP   s_ready=0. Counts GAP_CYC cycles, then -> IDLE.
//  Changes to cfg_* during a burst have no effect until the next IDLE accept.
//  Decision, combinational on s_data:
//    DC: inv = (number of zero bits > 4) = maj9({~s_data, 1'b0}).
//    AC: inv = (popcount(s_data ^ prev) > 4) = maj9({s_data ^ prev, 1'b0}).
//    Exactly 4 zeros or 4 toggles -> no inversion (tie goes to non-inverted).
//    cfg_en=0 -> inv=0.
//  Latency: 1 cycle. The accepted beat appears on o_dq/o_dbi/o_last at the next edge,
//    and is held stable while o_valid & !o_ready.
//  prev updates to the registered o_dq value when a beat is accepted downstream.
//    It persists across bursts and GAP; only rst sets it back to 8'hFF.
//  AC evaluation uses prev as updated by all earlier downstream-accepted beats.
//    If the previous beat is still held in the output register at input accept,
//    compare against that held o_dq, not the stale prev.
//  inv_cnt accumulates per burst, is captured on done, then clears the accumulator.
//    It cannot overflow because BL <= 255.
//  Simultaneous events:
//    - Output acceptance and new input acceptance in the same cycle is legal; full
//      throughput is 1 beat/cycle.
//    - done and the IDLE transition may coincide when GAP_CYC = 0.
//  rst mid-burst: aborts immediately. The partial burst is discarded, no done pulse,
//    all reset values are applied.
// STRUCTURE
//  Shared package dbi_pkg:
//    - state enum {IDLE, BURST, GAP}
//    - localparam DBI_DC = 1'b0, DBI_AC = 1'b1
//    - localparam DQ_PARK = 8'hFF
//  One sub-module, dbi_maj9: 9-input majority (out = 1 when >= 5 inputs are 1), purely
//    combinational, instantiated once with the input muxed by mode.
//  Controller holds the FSM, beat/gap counters, output register, prev register and
//    inv accumulator.
// TESTING
//  1 DC, BL=8, o_ready=1, data 00,0F,07,FF,F0,01,80,AA ->
//    o_dq  FF,0F,F8,FF,F0,FE,7F,AA
//    o_dbi 1,0,1,0,0,1,1,0
//    o_last on beat 8, done with inv_cnt=4, then s_ready low for 2 cycles.
//  2 AC from reset (prev=FF), data 00,00,0F ->
//    beat1: toggles=8 -> o_dq=FF, o_dbi=1
//    beat2: same -> FF, 1
//    beat3: 0F vs FF has 4 toggles (tie) -> 0F, 0
//  3 Backpressure: o_ready=0 for 3 cycles mid-burst ->
//    o_dq/o_dbi/o_last held, s_ready=0, no beat lost or duplicated, inv_cnt unchanged.
//  4 cfg_mode toggled DC->AC at beat 3 of a DC burst ->
//    remaining beats still DC-encoded; the next burst uses AC with prev = last o_dq.
//  5 rst asserted at beat 5 ->
//    next cycle all outputs at reset values, no done pulse; new burst starts cleanly at beat 1.
//  6 cfg_en=0, data 00 x8 ->
//    o_dq=00 and o_dbi=0 on all beats, inv_cnt=0.

Source files
------------

// File: rtl/dbi_pkg.sv
// Shared types and constants for the byte-lane DBI transmit controller.
package dbi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } dbi_state_e;

    localparam logic       DBI_DC  = 1'b0;
    localparam logic       DBI_AC  = 1'b1;
    localparam logic [7:0] DQ_PARK = 8'hFF;

endpackage

// File: rtl/dbi_maj9.sv
// 9-input majority voter: o_maj = 1 when at least five inputs are 1.
module dbi_maj9 (
    input  logic [8:0] i_vote,
    output logic       o_maj
);

    logic [3:0] w_cnt;

    // Population count of the nine votes.
    always_comb begin
        w_cnt = 4'd0;
        for (int k = 0; k < 9; k++) begin
            w_cnt = w_cnt + {3'b000, i_vote[k]};
        end
    end

    assign o_maj = (w_cnt >= 4'd5);

endmodule

// File: rtl/dbi_burst_ctrl.sv
// Byte-lane DBI transmit controller: per-beat DC/AC inversion decision,
// single-register output stage, burst length / inter-burst gap enforcement
// and per-burst inversion count.
module dbi_burst_ctrl
    import dbi_pkg::*;
#(
    parameter int BL      = 8,
    parameter int GAP_CYC = 2,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_mode,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o_dq,
    output logic         o_dbi,
    output logic         o_last,
    output logic         done,
    output logic [7:0]   inv_cnt
);

    localparam logic [7:0] BEAT_LAST = 8'(BL - 1);
    localparam logic [7:0] BEAT_END  = 8'(BL);
    localparam logic [3:0] GAP_LAST  = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic       HAS_GAP   = (GAP_CYC > 0);

    dbi_state_e r_state;
    dbi_state_e w_state_nx;

    logic [7:0]   r_beat_cnt;
    logic [3:0]   r_gap_cnt;
    logic         r_en;
    logic         r_mode;
    logic         r_o_valid;
    logic [W-1:0] r_o_dq;
    logic         r_o_dbi;
    logic         r_o_last;
    logic [W-1:0] r_prev;
    logic [7:0]   r_inv_acc;
    logic [7:0]   r_inv_cnt;
    logic         r_done;

    logic         w_s_ready;
    logic         w_in_acc;
    logic         w_out_acc;
    logic         w_last_out;
    logic         w_en;
    logic         w_mode;
    logic [W-1:0] w_ref;
    logic [8:0]   w_vote;
    logic         w_maj;
    logic         w_inv;
    logic [W-1:0] w_enc;

    assign w_out_acc  = r_o_valid & o_ready;
    assign w_last_out = w_out_acc & r_o_last;

    // Next-state and input-ready decode.
    always_comb begin
        w_state_nx = r_state;
        w_s_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    w_state_nx = BURST;
                end
            end
            BURST: begin
                // Once all BL beats are in, hold off until the last one drains.
                w_s_ready = (r_beat_cnt != BEAT_END) & (~r_o_valid | o_ready);
                if (w_last_out) begin
                    w_state_nx = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign s_ready  = w_s_ready & ~rst;
    assign w_in_acc = s_valid & s_ready;

    // The first beat of a burst uses the live config; later beats use the latched copy.
    assign w_en   = (r_state == IDLE) ? cfg_en   : r_en;
    assign w_mode = (r_state == IDLE) ? cfg_mode : r_mode;

    // A beat still sitting in the output register is what the bus will carry
    // just before this one, so it is the AC reference rather than r_prev.
    assign w_ref  = r_o_valid ? r_o_dq : r_prev;

    // Ninth vote tied low so an exact 4/4 split resolves to non-inverted.
    assign w_vote = (w_mode == DBI_AC) ? {s_data ^ w_ref, 1'b0} : {~s_data, 1'b0};

    dbi_maj9 u_maj9 (
        .i_vote (w_vote),
        .o_maj  (w_maj)
    );

    assign w_inv = w_en & w_maj;
    assign w_enc = w_inv ? ~s_data : s_data;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Beat counter: counts accepted input beats, cleared when the burst drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= 8'd0;
        end else if (w_last_out) begin
            r_beat_cnt <= 8'd0;
        end else if (w_in_acc) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Gap counter: runs only while in GAP and rewinds on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= 4'd0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? 4'd0 : (r_gap_cnt + 4'd1);
        end else begin
            r_gap_cnt <= 4'd0;
        end
    end

    // Burst configuration latch, captured on the first accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_mode <= DBI_DC;
        end else if ((r_state == IDLE) && w_in_acc) begin
            r_en   <= cfg_en;
            r_mode <= cfg_mode;
        end
    end

    // Output register: loads on input accept, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_dq    <= DQ_PARK;
            r_o_dbi   <= 1'b0;
            r_o_last  <= 1'b0;
        end else if (w_in_acc) begin
            r_o_valid <= 1'b1;
            r_o_dq    <= w_enc;
            r_o_dbi   <= w_inv;
            r_o_last  <= (r_beat_cnt == BEAT_LAST);
        end else if (o_ready) begin
            r_o_valid <= 1'b0;
        end
    end

    // AC reference: last byte actually taken by the downstream side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= DQ_PARK;
        end else if (w_out_acc) begin
            r_prev <= r_o_dq;
        end
    end

    // Inversion statistics and the done pulse for the drained burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_acc <= 8'd0;
            r_inv_cnt <= 8'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last_out;
            if (w_last_out) begin
                r_inv_cnt <= r_inv_acc;
                r_inv_acc <= 8'd0;
            end else if (w_in_acc && w_inv) begin
                r_inv_acc <= r_inv_acc + 8'd1;
            end
        end
    end

    assign o_valid = r_o_valid;
    assign o_dq    = r_o_dq;
    assign o_dbi   = r_o_dbi;
    assign o_last  = r_o_last;
    assign done    = r_done;
    assign inv_cnt = r_inv_cnt;

endmodule

// File: tb/tb_dbi_burst_ctrl.sv
// Testbench for dbi_burst_ctrl: transaction-level reference model with
// randomized handshakes and data plus directed scenarios.
module tb_dbi_burst_ctrl;

    localparam int BL      = 8;
    localparam int GAP_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_en = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       o_valid;
    logic       o_ready = 1'b0;
    logic [7:0] o_dq;
    logic       o_dbi;
    logic       o_last;
    logic       done;
    logic [7:0] inv_cnt;

    dbi_burst_ctrl #(.BL(BL), .GAP_CYC(GAP_CYC), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .cfg_mode (cfg_mode),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_dq     (o_dq),
        .o_dbi    (o_dbi),
        .o_last   (o_last),
        .done     (done),
        .inv_cnt  (inv_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stream of source bytes, stream of expected encoded beats.
    logic [7:0] din_q[$];
    logic [9:0] exp_q[$];          // {last, dbi, dq}
    logic [7:0] cap_dq[$];
    logic       cap_dbi[$];
    int         m_beats;           // beats taken into the current burst
    int         m_gap;             // remaining forced idle cycles
    logic       m_en, m_mode;      // config of the current burst
    logic [7:0] m_ref;             // last encoded byte in stream order
    int         m_acc;
    logic [7:0] m_inv;
    logic       m_done;
    logic [7:0] m_hold_dq;

    int kv = 100;
    int kr = 100;
    int stall = 0;
    bit jitter = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] encode(input logic [7:0] d, input logic en, input logic mode,
                                          input logic [7:0] rf, input logic last);
        int  n;
        logic inv;
        n   = mode ? $countones(d ^ rf) : 8 - $countones(d);
        inv = en && (n > 4);
        return {last, inv, (inv ? ~d : d)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_beats   = 0;
        m_gap     = 0;
        m_en      = 1'b0;
        m_mode    = 1'b0;
        m_ref     = 8'hFF;
        m_acc     = 0;
        m_inv     = 8'h00;
        m_done    = 1'b0;
        m_hold_dq = 8'hFF;
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_dq",    o_dq,    8'hFF);
        chk("rst_o_dbi",   o_dbi,   1'b0);
        chk("rst_o_last",  o_last,  1'b0);
        chk("rst_done",    done,    1'b0);
        chk("rst_inv_cnt", inv_cnt, 8'h00);
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic tick();
        logic       exp_srdy;
        logic [9:0] e;
        logic [7:0] d;
        s_valid = (din_q.size() > 0) && ($urandom_range(99) < kv);
        s_data  = (din_q.size() > 0) ? din_q[0] : 8'($urandom);
        if (stall > 0) begin
            o_ready = 1'b0;
            stall--;
        end else begin
            o_ready = ($urandom_range(99) < kr);
        end
        if (jitter && ($urandom_range(7) == 0)) cfg_mode = ~cfg_mode;
        @(negedge clk);
        exp_srdy = !rst && (m_gap == 0) && (m_beats < BL) && ((exp_q.size() == 0) || o_ready);
        chk("s_ready", s_ready, exp_srdy);
        chk("o_valid", o_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("o_dq",   o_dq,   e[7:0]);
            chk("o_dbi",  o_dbi,  e[8]);
            chk("o_last", o_last, e[9]);
        end else begin
            chk("o_dq_hold", o_dq, m_hold_dq);
        end
        chk("done", done, m_done);
        chk("inv_cnt", inv_cnt, m_inv);
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_gap > 0) m_gap--;
            if ((exp_q.size() != 0) && o_ready) begin
                e = exp_q.pop_front();
                m_hold_dq = e[7:0];
                cap_dq.push_back(e[7:0]);
                cap_dbi.push_back(e[8]);
                if (e[9]) begin
                    m_done  = 1'b1;
                    m_inv   = 8'(m_acc);
                    m_acc   = 0;
                    m_beats = 0;
                    m_gap   = GAP_CYC;
                end
            end
            if (s_valid && exp_srdy) begin
                if (m_beats == 0) begin
                    m_en   = cfg_en;
                    m_mode = cfg_mode;
                end
                d = din_q.pop_front();
                e = encode(d, m_en, m_mode, m_ref, (m_beats == BL - 1));
                exp_q.push_back(e);
                m_ref = e[7:0];
                if (e[8]) m_acc++;
                m_beats++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int max_cyc);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (din_q.size() == 0 && exp_q.size() == 0 && !m_done && m_gap == 0 && m_beats == 0) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        chk("run_timeout", idle, 1'b1);
    endtask

    task automatic run_to_beat(input int n, input int max_cyc);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (m_beats >= n) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("beat_timeout", hit, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        o_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        din_q.delete();
        check_reset_vals();
        rst = 1'b0;
    endtask

    logic [7:0] t1_in  [8] = '{8'h00, 8'h0F, 8'h07, 8'hFF, 8'hF0, 8'h01, 8'h80, 8'hAA};
    logic [7:0] t1_dq  [8] = '{8'hFF, 8'h0F, 8'hF8, 8'hFF, 8'hF0, 8'hFE, 8'h7F, 8'hAA};
    logic       t1_dbi [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        model_reset();
        do_reset();

        // DC burst with the reference data, downstream always ready.
        cfg_en = 1'b1; cfg_mode = 1'b0; kv = 100; kr = 100;
        cap_dq.delete(); cap_dbi.delete();
        for (int i = 0; i < 8; i++) din_q.push_back(t1_in[i]);
        run_idle(100);
        chk("t1_count", cap_dq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_dq",  cap_dq[i],  t1_dq[i]);
            chk("t1_dbi", cap_dbi[i], t1_dbi[i]);
        end
        chk("t1_inv_cnt", inv_cnt, 8'd4);

        // AC from reset: 00,00,0F against parked FF.
        do_reset();
        cfg_en = 1'b1; cfg_mode = 1'b1;
        cap_dq.delete(); cap_dbi.delete();
        din_q.push_back(8'h00); din_q.push_back(8'h00); din_q.push_back(8'h0F);
        for (int i = 3; i < BL; i++) din_q.push_back(8'($urandom));
        run_idle(100);
        chk("t2_dq0", cap_dq[0], 8'hFF);  chk("t2_dbi0", cap_dbi[0], 1'b1);
        chk("t2_dq1", cap_dq[1], 8'hFF);  chk("t2_dbi1", cap_dbi[1], 1'b1);
        chk("t2_dq2", cap_dq[2], 8'h0F);  chk("t2_dbi2", cap_dbi[2], 1'b0);

        // Backpressure: three stalled cycles mid-burst.
        cfg_mode = 1'b0;
        for (int i = 0; i < BL; i++) din_q.push_back(8'($urandom));
        run_to_beat(4, 50);
        stall = 3;
        run_idle(100);

        // Mode flipped DC->AC at beat 3; next burst runs AC.
        cfg_mode = 1'b0;
        for (int i = 0; i < BL; i++) din_q.push_back(8'($urandom));
        run_to_beat(3, 50);
        cfg_mode = 1'b1;
        run_idle(100);
        for (int i = 0; i < BL; i++) din_q.push_back(8'($urandom));
        run_idle(100);

        // Reset at beat 5 discards the burst; a fresh burst follows.
        for (int i = 0; i < BL; i++) din_q.push_back(8'($urandom));
        run_to_beat(5, 50);
        rst = 1'b1;
        tick();
        check_reset_vals();
        din_q.delete();
        rst = 1'b0;
        cfg_mode = 1'b1;
        for (int i = 0; i < BL; i++) din_q.push_back(8'($urandom));
        run_idle(100);

        // DBI disabled: zeros pass through untouched.
        cfg_en = 1'b0;
        cap_dq.delete(); cap_dbi.delete();
        for (int i = 0; i < BL; i++) din_q.push_back(8'h00);
        run_idle(100);
        for (int i = 0; i < BL; i++) begin
            chk("t6_dq",  cap_dq[i],  8'h00);
            chk("t6_dbi", cap_dbi[i], 1'b0);
        end
        chk("t6_inv_cnt", inv_cnt, 8'd0);

        // Randomized bursts with random handshakes and config churn.
        jitter = 1;
        for (int b = 0; b < 12; b++) begin
            cfg_en   = 1'($urandom);
            cfg_mode = 1'($urandom);
            kv = 40 + $urandom_range(60);
            kr = 30 + $urandom_range(70);
            for (int i = 0; i < BL; i++) begin
                case ($urandom_range(3))
                    0: din_q.push_back(8'h00);
                    1: din_q.push_back(8'hFF);
                    default: din_q.push_back(8'($urandom));
                endcase
            end
            run_idle(400);
        end
        jitter = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
